// File: rtl/sudoku_game_ctrl.sv
// Game controller for a sudoku board: difficulty selection, cursor movement,
// number picking with strike counting, and a per-game countdown timer.
module sudoku_game_ctrl #(
    parameter int N           = 9,
    parameter int VAL_W       = 4,
    parameter int LEVELS      = 3,
    parameter int MAX_STRIKES = 3,
    parameter int TIME_W      = 11,
    parameter int TIME_BASE   = 600,
    parameter int TIME_STEP   = 150,
    localparam int POS_W = $clog2(N),
    localparam int IDX_W = $clog2(N * N),
    localparam int LVL_W = ($clog2(LEVELS) > 1) ? $clog2(LEVELS) : 1,
    localparam int STK_W = $clog2(MAX_STRIKES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_button,
    input  logic              down_button,
    input  logic              left_button,
    input  logic              right_button,
    input  logic              start_button,
    input  logic              a_button,
    input  logic              b_button,
    input  logic              tick,
    input  logic              load_done,
    input  logic              cell_visible,
    input  logic [VAL_W-1:0]  cell_value,
    input  logic              all_visible,
    output logic [2:0]        state,
    output logic [POS_W-1:0]  pos_i,
    output logic [POS_W-1:0]  pos_j,
    output logic [IDX_W-1:0]  index,
    output logic [VAL_W-1:0]  selected_number,
    output logic [LVL_W-1:0]  difficulty,
    output logic [STK_W-1:0]  strikes,
    output logic [TIME_W-1:0] time_left,
    output logic              load_req,
    output logic              commit,
    output logic              error,
    output logic              playing
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        LOADING  = 3'd2,
        NAVIGATE = 3'd3,
        PICK     = 3'd4,
        PAUSED   = 3'd5,
        VICTORY  = 3'd6,
        DEFEAT   = 3'd7
    } state_t;

    state_t             r_state;
    logic [POS_W-1:0]   r_pos_i, r_pos_j;
    logic [VAL_W-1:0]   r_sel;
    logic [LVL_W-1:0]   r_difficulty;
    logic [STK_W-1:0]   r_strikes;
    logic [TIME_W-1:0]  r_time_left;
    logic               r_load_req, r_commit, r_error;
    logic               w_playing, w_lose;

    // Starting time for a level, clamped at zero for very hard levels.
    function automatic logic [TIME_W-1:0] level_time(input logic [LVL_W-1:0] lvl);
        int t;
        t = TIME_BASE - int'(lvl) * TIME_STEP;
        return (t > 0) ? TIME_W'(t) : '0;
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
        return (p == '0) ? POS_W'(N - 1) : p - 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
        return (p == POS_W'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [VAL_W-1:0] val_inc(input logic [VAL_W-1:0] v);
        return (v == VAL_W'(N)) ? VAL_W'(1) : v + 1'b1;
    endfunction

    function automatic logic [VAL_W-1:0] val_dec(input logic [VAL_W-1:0] v);
        return (v == VAL_W'(1)) ? VAL_W'(N) : v - 1'b1;
    endfunction

    assign w_playing = (r_state == NAVIGATE) || (r_state == PICK);
    assign w_lose    = (r_strikes == STK_W'(MAX_STRIKES)) || (r_time_left == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pos_i      <= '0;
            r_pos_j      <= '0;
            r_sel        <= VAL_W'(1);
            r_difficulty <= '0;
            r_strikes    <= '0;
            r_time_left  <= '0;
            r_load_req   <= 1'b0;
            r_commit     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            r_error  <= 1'b0;
            if (w_playing && tick && (r_time_left != '0))
                r_time_left <= r_time_left - 1'b1;

            // Loss and win conditions override every button while in play.
            if (w_playing && w_lose) begin
                r_state <= DEFEAT;
            end else if (w_playing && all_visible) begin
                r_state <= VICTORY;
            end else begin
                case (r_state)
                    IDLE: if (start_button) r_state <= SELECT;
                    SELECT: begin
                        if (a_button) begin
                            r_state     <= LOADING;
                            r_load_req  <= 1'b1;
                            r_strikes   <= '0;
                            r_pos_i     <= '0;
                            r_pos_j     <= '0;
                            r_time_left <= level_time(r_difficulty);
                        end else if (up_button) begin
                            if (r_difficulty != LVL_W'(LEVELS - 1))
                                r_difficulty <= r_difficulty + 1'b1;
                        end else if (down_button) begin
                            if (r_difficulty != '0)
                                r_difficulty <= r_difficulty - 1'b1;
                        end
                    end
                    LOADING: begin
                        if (load_done) begin
                            r_state    <= NAVIGATE;
                            r_load_req <= 1'b0;
                        end
                    end
                    NAVIGATE: begin
                        if (start_button)                  r_state <= PAUSED;
                        else if (a_button && !cell_visible) begin
                            r_state <= PICK;
                            r_sel   <= VAL_W'(1);
                        end
                        else if (up_button)                r_pos_i <= pos_dec(r_pos_i);
                        else if (down_button)              r_pos_i <= pos_inc(r_pos_i);
                        else if (left_button)              r_pos_j <= pos_dec(r_pos_j);
                        else if (right_button)             r_pos_j <= pos_inc(r_pos_j);
                    end
                    PICK: begin
                        if (start_button)      r_state <= PAUSED;
                        else if (b_button)     r_state <= NAVIGATE;
                        else if (a_button) begin
                            if (r_sel == cell_value) begin
                                r_commit <= 1'b1;
                                r_state  <= NAVIGATE;
                            end else begin
                                r_error <= 1'b1;
                                if (r_strikes != STK_W'(MAX_STRIKES))
                                    r_strikes <= r_strikes + 1'b1;
                            end
                        end
                        else if (up_button)    r_sel <= val_inc(r_sel);
                        else if (down_button)  r_sel <= val_dec(r_sel);
                    end
                    PAUSED:  if (start_button) r_state <= NAVIGATE;
                    VICTORY, DEFEAT: if (start_button) r_state <= SELECT;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign state           = r_state;
    assign pos_i           = r_pos_i;
    assign pos_j           = r_pos_j;
    assign index           = IDX_W'(r_pos_i) * IDX_W'(N) + IDX_W'(r_pos_j);
    assign selected_number = r_sel;
    assign difficulty      = r_difficulty;
    assign strikes         = r_strikes;
    assign time_left       = r_time_left;
    assign load_req        = r_load_req;
    assign commit          = r_commit;
    assign error           = r_error;
    assign playing         = w_playing;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Bench for sudoku_game_ctrl: vector table, directed corner sequences and
// randomized play compared against a game-rules model.
module tb_sudoku_game_ctrl;

    localparam int N = 9;
    localparam int LEVELS = 3;
    localparam int MAXS = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic up_button = 0, down_button = 0, left_button = 0, right_button = 0;
    logic start_button = 0, a_button = 0, b_button = 0;
    logic tick = 0, load_done = 0, cell_visible = 0, all_visible = 0;
    logic [3:0]  cell_value = 4'd1;
    logic [2:0]  state;
    logic [3:0]  pos_i, pos_j;
    logic [6:0]  index;
    logic [3:0]  selected_number;
    logic [1:0]  difficulty;
    logic [1:0]  strikes;
    logic [10:0] time_left;
    logic        load_req, commit, error, playing;

    int checks = 0;
    int failures = 0;

    sudoku_game_ctrl dut (
        .clk(clk), .reset(reset),
        .up_button(up_button), .down_button(down_button),
        .left_button(left_button), .right_button(right_button),
        .start_button(start_button), .a_button(a_button), .b_button(b_button),
        .tick(tick), .load_done(load_done), .cell_visible(cell_visible),
        .cell_value(cell_value), .all_visible(all_visible),
        .state(state), .pos_i(pos_i), .pos_j(pos_j), .index(index),
        .selected_number(selected_number), .difficulty(difficulty),
        .strikes(strikes), .time_left(time_left), .load_req(load_req),
        .commit(commit), .error(error), .playing(playing)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] BS = 7'b1000000, BU = 7'b0100000, BD = 7'b0010000,
                           BL = 7'b0001000, BR = 7'b0000100, BA = 7'b0000010,
                           BB = 7'b0000001, B0 = 7'b0000000;

    typedef struct {
        logic [6:0] btn;
        logic       tk, ld, vis;
        logic [3:0] val;
        int st, pi, pj, sel, dif, stk, tl, lr, cm, er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [6:0] btn, logic tk, logic ld, logic vis, logic [3:0] val,
                                int st, int pi, int pj, int sel, int dif, int stk, int tl,
                                int lr, int cm, int er);
        vec_t r;
        r.btn = btn; r.tk = tk; r.ld = ld; r.vis = vis; r.val = val;
        r.st = st; r.pi = pi; r.pj = pj; r.sel = sel; r.dif = dif; r.stk = stk;
        r.tl = tl; r.lr = lr; r.cm = cm; r.er = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] btn, input logic tk, input logic ld, input logic vis,
                         input logic [3:0] val, input logic allv);
        {start_button, up_button, down_button, left_button, right_button, a_button, b_button} = btn;
        tick = tk; load_done = ld; cell_visible = vis; cell_value = val; all_visible = allv;
    endtask

    task automatic step(input logic [6:0] btn, input logic tk, input logic ld, input logic vis,
                        input logic [3:0] val, input logic allv);
        drive(btn, tk, ld, vis, val, allv);
        @(posedge clk);
        #1;
        drive(B0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    endtask

    // Reference model: game rules expressed with plain integer arithmetic.
    int m_st, m_i, m_j, m_sel, m_dif, m_stk, m_tl, m_lr, m_cm, m_er;

    task automatic model_reset();
        m_st = 0; m_i = 0; m_j = 0; m_sel = 1; m_dif = 0; m_stk = 0; m_tl = 0;
        m_lr = 0; m_cm = 0; m_er = 0;
    endtask

    task automatic model_step(input logic [6:0] btn, input logic tk, input logic ld,
                              input logic vis, input int val, input logic allv);
        int old_tl;
        bit play, sb, ub, db, lb, rb, ab, bb;
        {sb, ub, db, lb, rb, ab, bb} = btn;
        old_tl = m_tl;
        play = (m_st == 3) || (m_st == 4);
        m_cm = 0; m_er = 0;
        if (play && tk && m_tl > 0) m_tl = m_tl - 1;
        if (play && (m_stk == MAXS || old_tl == 0)) m_st = 7;
        else if (play && allv) m_st = 6;
        else begin
            case (m_st)
                0: if (sb) m_st = 1;
                1: begin
                    if (ab) begin
                        m_st = 2; m_lr = 1; m_stk = 0; m_i = 0; m_j = 0;
                        m_tl = 600 - 150 * m_dif;
                        if (m_tl < 0) m_tl = 0;
                    end else if (ub) begin
                        if (m_dif < LEVELS - 1) m_dif++;
                    end else if (db) begin
                        if (m_dif > 0) m_dif--;
                    end
                end
                2: if (ld) begin m_st = 3; m_lr = 0; end
                3: begin
                    if (sb) m_st = 5;
                    else if (ab && !vis) begin m_st = 4; m_sel = 1; end
                    else if (ub) m_i = (m_i + N - 1) % N;
                    else if (db) m_i = (m_i + 1) % N;
                    else if (lb) m_j = (m_j + N - 1) % N;
                    else if (rb) m_j = (m_j + 1) % N;
                end
                4: begin
                    if (sb) m_st = 5;
                    else if (bb) m_st = 3;
                    else if (ab) begin
                        if (m_sel == val) begin m_cm = 1; m_st = 3; end
                        else begin m_er = 1; if (m_stk < MAXS) m_stk++; end
                    end
                    else if (ub) m_sel = m_sel % N + 1;
                    else if (db) m_sel = (m_sel + N - 2) % N + 1;
                end
                5: if (sb) m_st = 3;
                default: if (sb) m_st = 1;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_st));
        chk({tag, ".pos_i"}, 32'(pos_i), 32'(m_i));
        chk({tag, ".pos_j"}, 32'(pos_j), 32'(m_j));
        chk({tag, ".index"}, 32'(index), 32'(m_i * N + m_j));
        chk({tag, ".sel"}, 32'(selected_number), 32'(m_sel));
        chk({tag, ".difficulty"}, 32'(difficulty), 32'(m_dif));
        chk({tag, ".strikes"}, 32'(strikes), 32'(m_stk));
        chk({tag, ".time_left"}, 32'(time_left), 32'(m_tl));
        chk({tag, ".load_req"}, 32'(load_req), 32'(m_lr));
        chk({tag, ".commit"}, 32'(commit), 32'(m_cm));
        chk({tag, ".error"}, 32'(error), 32'(m_er));
        chk({tag, ".playing"}, 32'(playing), 32'((m_st == 3) || (m_st == 4)));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".state"}, 32'(state), 0);
        chk({tag, ".pos_i"}, 32'(pos_i), 0);
        chk({tag, ".pos_j"}, 32'(pos_j), 0);
        chk({tag, ".sel"}, 32'(selected_number), 1);
        chk({tag, ".difficulty"}, 32'(difficulty), 0);
        chk({tag, ".strikes"}, 32'(strikes), 0);
        chk({tag, ".time_left"}, 32'(time_left), 0);
        chk({tag, ".load_req"}, 32'(load_req), 0);
        chk({tag, ".commit"}, 32'(commit), 0);
        chk({tag, ".error"}, 32'(error), 0);
    endtask

    initial begin
        // btn tick ld vis val | st pi pj sel dif stk tl lr cm er
        tbl.push_back(mk(BS, 0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 0,   0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 0,   0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 0,   0, 0, 0));
        tbl.push_back(mk(BA, 0, 0, 0, 1,  2, 0, 0, 1, 2, 0, 300, 1, 0, 0));
        tbl.push_back(mk(B0, 0, 0, 0, 1,  2, 0, 0, 1, 2, 0, 300, 1, 0, 0));
        tbl.push_back(mk(B0, 0, 1, 0, 1,  3, 0, 0, 1, 2, 0, 300, 0, 0, 0));
        tbl.push_back(mk(BU, 1, 0, 0, 1,  3, 8, 0, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BL, 0, 0, 0, 1,  3, 8, 8, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BU|BD|BL|BR, 0, 0, 0, 1, 3, 7, 8, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BD, 0, 0, 0, 1,  3, 8, 8, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BD, 0, 0, 0, 1,  3, 0, 8, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BR, 0, 0, 0, 1,  3, 0, 0, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BA, 0, 0, 1, 5,  3, 0, 0, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BA, 0, 0, 0, 5,  4, 0, 0, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 5,  4, 0, 0, 2, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 5,  4, 0, 0, 3, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 5,  4, 0, 0, 4, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 5,  4, 0, 0, 5, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BA, 0, 0, 0, 5,  3, 0, 0, 5, 2, 0, 299, 0, 1, 0));
        tbl.push_back(mk(B0, 0, 0, 0, 5,  3, 0, 0, 5, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BA, 0, 0, 0, 2,  4, 0, 0, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BD, 0, 0, 0, 2,  4, 0, 0, 9, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 2,  4, 0, 0, 1, 2, 0, 299, 0, 0, 0));
        tbl.push_back(mk(BA, 0, 0, 0, 2,  4, 0, 0, 1, 2, 1, 299, 0, 0, 1));
        tbl.push_back(mk(BA, 0, 0, 0, 2,  4, 0, 0, 1, 2, 2, 299, 0, 0, 1));
        tbl.push_back(mk(BA, 0, 0, 0, 2,  4, 0, 0, 1, 2, 3, 299, 0, 0, 1));
        tbl.push_back(mk(B0, 0, 0, 0, 2,  7, 0, 0, 1, 2, 3, 299, 0, 0, 0));
        tbl.push_back(mk(BU, 0, 0, 0, 2,  7, 0, 0, 1, 2, 3, 299, 0, 0, 0));
        tbl.push_back(mk(BS, 0, 0, 0, 2,  1, 0, 0, 1, 2, 3, 299, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            string tg;
            tg = $sformatf("vec%0d", k);
            step(tbl[k].btn, tbl[k].tk, tbl[k].ld, tbl[k].vis, tbl[k].val, 1'b0);
            chk({tg, ".state"}, 32'(state), 32'(tbl[k].st));
            chk({tg, ".pos_i"}, 32'(pos_i), 32'(tbl[k].pi));
            chk({tg, ".pos_j"}, 32'(pos_j), 32'(tbl[k].pj));
            chk({tg, ".index"}, 32'(index), 32'(tbl[k].pi * N + tbl[k].pj));
            chk({tg, ".sel"}, 32'(selected_number), 32'(tbl[k].sel));
            chk({tg, ".difficulty"}, 32'(difficulty), 32'(tbl[k].dif));
            chk({tg, ".strikes"}, 32'(strikes), 32'(tbl[k].stk));
            chk({tg, ".time_left"}, 32'(time_left), 32'(tbl[k].tl));
            chk({tg, ".load_req"}, 32'(load_req), 32'(tbl[k].lr));
            chk({tg, ".commit"}, 32'(commit), 32'(tbl[k].cm));
            chk({tg, ".error"}, 32'(error), 32'(tbl[k].er));
            chk({tg, ".playing"}, 32'(playing), 32'((tbl[k].st == 3) || (tbl[k].st == 4)));
        end

        // Pause freezes the timer; running out of time beats a full board.
        step(BA, 0, 0, 0, 1, 0);
        chk("timer.load_time", 32'(time_left), 300);
        step(B0, 0, 1, 0, 1, 0);
        repeat (290) step(B0, 1, 0, 0, 1, 0);
        chk("timer.at10", 32'(time_left), 10);
        step(BS, 0, 0, 0, 1, 0);
        chk("timer.paused", 32'(state), 5);
        repeat (5) step(B0, 1, 0, 0, 1, 0);
        chk("timer.frozen", 32'(time_left), 10);
        chk("timer.still_paused", 32'(state), 5);
        step(BS, 0, 0, 0, 1, 0);
        chk("timer.resumed", 32'(state), 3);
        repeat (10) step(B0, 1, 0, 0, 1, 0);
        chk("timer.zero", 32'(time_left), 0);
        chk("timer.not_yet_defeat", 32'(state), 3);
        step(B0, 0, 0, 0, 1, 1);
        chk("timer.defeat_over_victory", 32'(state), 7);
        step(BS, 0, 0, 0, 1, 0);
        chk("timer.back_to_select", 32'(state), 1);

        // Asynchronous reset in the middle of a pick.
        step(BA, 0, 0, 0, 1, 0);
        step(B0, 0, 1, 0, 1, 0);
        step(BA, 0, 0, 0, 7, 0);
        step(BU, 0, 0, 0, 7, 0);
        chk("midpick.state", 32'(state), 4);
        chk("midpick.sel", 32'(selected_number), 2);
        reset = 1'b0;
        #2;
        check_reset_vals("async_reset");
        #1;
        reset = 1'b1;
        step(BS, 0, 0, 0, 1, 0);
        chk("resume.state", 32'(state), 1);
        step(BA, 0, 0, 0, 1, 0);
        chk("resume.time_lvl0", 32'(time_left), 600);
        step(B0, 0, 1, 0, 1, 0);
        step(B0, 0, 0, 0, 1, 1);
        chk("victory.state", 32'(state), 6);
        step(BS, 0, 0, 0, 1, 0);
        chk("victory.to_select", 32'(state), 1);

        // Randomized play against the rules model.
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            logic [6:0] btn;
            logic tk, ld, vis, allv;
            int val;
            if ($urandom_range(0, 699) == 0) begin
                drive(B0, 0, 0, 0, 4'd1, 0);
                reset = 1'b0;
                model_reset();
                #2;
                check_all("rnd_reset");
                reset = 1'b1;
            end
            btn[6] = ($urandom_range(0, 11) == 0);
            for (int b = 0; b < 6; b++) btn[b] = ($urandom_range(0, 3) == 0);
            tk   = ($urandom_range(0, 1) == 0);
            ld   = ($urandom_range(0, 2) == 0);
            vis  = ($urandom_range(0, 1) == 0);
            allv = ($urandom_range(0, 99) == 0);
            val  = $urandom_range(1, 9);
            drive(btn, tk, ld, vis, 4'(val), allv);
            model_step(btn, tk, ld, vis, val, allv);
            @(posedge clk);
            #1;
            check_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
